miriscv_fetch_unit_buf: RTL

// - Parametrised instruction fetch unit with request/grant memory handshake, multiple outstanding reads and an instruction FIFO.
// - Sits between the instruction memory port and the decode stage of the miriscv pipeline.
// - Decouples memory latency from decode stalls.
// - Discards in-flight responses after a PC redirect (branch/trap).

---
 rtl/miriscv_fetch_unit_buf.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/miriscv_fetch_unit_buf.sv
// Instruction fetch unit: req/gnt memory port, several reads in flight, instruction FIFO toward decode.
// Optional build macro MIRISCV_FETCH_MISALIGN_EN adds a sticky misaligned-redirect fault and fetch_misalign_o.
module miriscv_fetch_unit_buf #(
    parameter int              XLEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    output logic            instr_req_o,
    input  logic            instr_gnt_i,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    input  logic            cu_stall_f_i,
    input  logic            cu_force_f_i,
    input  logic [XLEN-1:0] cu_force_pc_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] fetched_pc_addr_o,
    output logic [XLEN-1:0] fetched_pc_next_addr_o,
`ifdef MIRISCV_FETCH_MISALIGN_EN
    output logic            fetch_misalign_o,
`endif
    output logic            fetch_rvalid_o
);

    localparam int ILEN = 32;
    localparam int FW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW   = CW + OW + 1;

    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_discard;

    // PC queue pairs each in-order response with the address that requested it
    logic [XLEN-1:0] r_pcq [MAX_OUTSTANDING];
    logic [QW-1:0]   r_pcq_wptr;
    logic [QW-1:0]   r_pcq_rptr;

    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [FW-1:0]   r_wptr;
    logic [FW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_fifo_empty;
    logic [SW-1:0]   w_credit_sum;
    logic            w_fault;
    logic            w_req;
    logic            w_hs;
    logic            w_resp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic [OW-1:0]   w_out_next;
    logic [XLEN-1:0] w_force_pc;
    logic [XLEN-1:0] w_head_data;
    logic [XLEN-1:0] w_head_pc;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        if (p == QW'(MAX_OUTSTANDING - 1)) return '0;
        return p + QW'(1);
    endfunction

`ifdef MIRISCV_FETCH_MISALIGN_EN
    logic r_fault;
    assign w_fault          = r_fault;
    assign fetch_misalign_o = r_fault;
    assign w_force_pc       = cu_force_pc_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_fault <= 1'b0;
        end else if (cu_force_f_i) begin
            r_fault <= |cu_force_pc_i[1:0];
        end
    end
`else
    assign w_fault    = 1'b0;
    assign w_force_pc = cu_force_pc_i & ~XLEN'(3);
`endif

    // Credit counts buffered plus live in-flight words; discarded ones will never occupy the FIFO
    assign w_fifo_empty = (r_count == '0);
    assign w_credit_sum = SW'(r_count) + SW'(r_outstanding) - SW'(r_discard);

    // Request is held low while reset is asserted so every output except the address reads zero
    assign w_req = arstn_i & ~cu_force_f_i & ~w_fault
                 & (r_outstanding < OW'(MAX_OUTSTANDING))
                 & (w_credit_sum < SW'(FIFO_DEPTH));

    assign w_hs       = w_req & instr_gnt_i;
    assign w_resp     = instr_rvalid_i;
    assign w_drop     = w_resp & (r_discard != '0);
    assign w_push     = w_resp & ~w_drop;
    assign w_pop      = fetch_rvalid_o & ~cu_stall_f_i;
    assign w_out_next = r_outstanding + OW'(w_hs) - OW'(w_resp);

    assign w_head_data = r_fifo_data[r_rptr];
    assign w_head_pc   = r_fifo_pc[r_rptr];

    assign instr_req_o            = w_req;
    assign instr_addr_o           = r_pc;
    assign fetch_rvalid_o         = ~w_fifo_empty & ~cu_force_f_i;
    assign instr_o                = w_fifo_empty ? '0 : w_head_data[ILEN-1:0];
    assign fetched_pc_addr_o      = w_fifo_empty ? '0 : w_head_pc;
    assign fetched_pc_next_addr_o = w_fifo_empty ? '0 : w_head_pc + XLEN'(4);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_pcq_wptr    <= '0;
            r_pcq_rptr    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_hs)   r_pcq_wptr <= q_inc(r_pcq_wptr);
            if (w_resp) r_pcq_rptr <= q_inc(r_pcq_rptr);

            if (cu_force_f_i) begin
                // Everything still in flight after this cycle belongs to the old stream
                r_pc      <= w_force_pc;
                r_discard <= w_out_next;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_count   <= '0;
            end else begin
                if (w_hs)   r_pc      <= r_pc + XLEN'(4);
                if (w_drop) r_discard <= r_discard - OW'(1);
                if (w_push) r_wptr    <= r_wptr + FW'(1);
                if (w_pop)  r_rptr    <= r_rptr + FW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs) r_pcq[r_pcq_wptr] <= r_pc;
        if (w_push && !cu_force_f_i) begin
            r_fifo_data[r_wptr] <= instr_rdata_i;
            r_fifo_pc[r_wptr]   <= r_pcq[r_pcq_rptr];
        end
    end

    a_rvalid_needs_outstanding : assert property (
        @(posedge clk_i) disable iff (!arstn_i) instr_rvalid_i |-> (r_outstanding != '0)
    );

endmodule
